// File: rtl/cache_control.sv
// Two-way set-associative cache controller: zero-wait hits, per-set LRU,
// optional dirty writeback followed by a line fill on a miss.
module cache_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  output logic        mem_resp,
  input  logic        hit_one,
  input  logic        hit_two,
  input  logic        dirty_one,
  input  logic        dirty_two,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  output logic [1:0]  pmem_addr_sel,
  output logic [1:0]  load_way,
  output logic [1:0]  write_way,
  output logic        out_way
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] lru_r;
  logic       victim_r;

  logic [2:0] index_s;
  logic       req_s;
  logic       hit_s;
  logic       hit_way_s;
  logic       lru_way_s;
  logic       victim_dirty_s;
  logic       lru_upd_s;
  logic       miss_s;
  logic       unused_addr_s;

  assign index_s        = mem_address[5:3];
  assign req_s          = mem_read | mem_write;
  assign hit_s          = hit_one | hit_two;
  assign hit_way_s      = ~hit_one;
  assign lru_way_s      = lru_r[index_s];
  assign victim_dirty_s = lru_way_s ? dirty_two : dirty_one;
  assign unused_addr_s  = ^{mem_address[15:6], mem_address[2:0]};

  // Next state and outputs; everything is forced low while reset is held.
  always_comb begin
    state_nxt_s   = state_r;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 2'b00;
    load_way      = 2'b00;
    write_way     = 2'b00;
    out_way       = 1'b0;
    lru_upd_s     = 1'b0;
    miss_s        = 1'b0;
    if (rst_n) begin
      case (state_r)
        IDLE: begin
          if (req_s && hit_s) begin
            mem_resp  = 1'b1;
            lru_upd_s = 1'b1;
            if (mem_write) begin
              write_way = hit_one ? 2'b01 : 2'b10;
            end else begin
              out_way = hit_way_s;
            end
          end else if (req_s) begin
            miss_s      = 1'b1;
            state_nxt_s = victim_dirty_s ? WRITEBACK : FILL;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = victim_r ? 2'b10 : 2'b01;
          if (pmem_resp) begin
            state_nxt_s = FILL;
          end else begin
            state_nxt_s = WRITEBACK;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_way    = victim_r ? 2'b10 : 2'b01;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = FILL;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // LRU points at the way that was not just hit; victim is latched only on the miss edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_r    <= 8'h00;
      victim_r <= 1'b0;
    end else begin
      if (lru_upd_s) begin
        lru_r[index_s] <= ~hit_way_s;
      end
      if (miss_s) begin
        victim_r <= lru_way_s;
      end
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Randomized transaction-level bench for cache_control with a per-set LRU
// reference model; checks every cycle's output bundle.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic        hit_one, hit_two, dirty_one, dirty_two;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  pmem_addr_sel, load_way, write_way;
  logic        out_way;

  int n_vec = 0;
  int n_err = 0;
  bit lru_m [8];

  // Output bundle: {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way, write_way, out_way}
  logic [9:0] obs;
  assign obs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way, write_way, out_way};

  cache_control dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp),
    .hit_one(hit_one), .hit_two(hit_two), .dirty_one(dirty_one), .dirty_two(dirty_two),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .pmem_addr_sel(pmem_addr_sel), .load_way(load_way), .write_way(write_way),
    .out_way(out_way)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ov(bit resp, bit pr, bit pw, logic [1:0] sel,
                                    logic [1:0] lw, logic [1:0] ww, bit ow);
    return {resp, pr, pw, sel, lw, ww, ow};
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (resp,pr,pw,sel,load,wr,out) t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven at posedge+1; outputs are sampled at the following negedge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_read = 1'b0; mem_write = 1'b0; hit_one = 1'b0; hit_two = 1'b0;
    dirty_one = 1'b0; dirty_two = 1'b0; pmem_resp = 1'b0;
  endtask

  function automatic logic [15:0] addr(logic [2:0] idx);
    logic [9:0] tag;
    logic [2:0] off;
    tag = 10'($urandom);
    off = 3'($urandom);
    return {tag, idx, off};
  endfunction

  task automatic idle_cyc();
    clear_in();
    mem_address = addr(3'($urandom));
    pmem_resp   = 1'($urandom);
    cyc("idle", 10'd0);
  endtask

  task automatic hit_req(input bit wr, input bit rd, input logic [2:0] idx, input bit h1, input bit h2);
    logic [1:0] ww;
    clear_in();
    mem_read = rd; mem_write = wr; mem_address = addr(idx);
    hit_one = h1; hit_two = h2;
    dirty_one = 1'($urandom); dirty_two = 1'($urandom);
    pmem_resp = 1'($urandom);
    ww = wr ? (h1 ? 2'b01 : 2'b10) : 2'b00;
    cyc(wr ? "write_hit" : "read_hit", ov(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, ww, !wr && !h1));
    lru_m[idx] = h1;
    clear_in();
  endtask

  task automatic miss_req(input bit wr, input bit rd, input logic [2:0] idx, input bit d1, input bit d2,
                          input int wbl, input int fl, input bit abort);
    bit         v, dirty;
    logic [1:0] vh, ww;
    v = lru_m[idx];
    dirty = v ? d2 : d1;
    vh = v ? 2'b10 : 2'b01;
    clear_in();
    mem_read = rd; mem_write = wr; mem_address = addr(idx);
    dirty_one = d1; dirty_two = d2;
    cyc("miss_idle", 10'd0);
    if (dirty) begin
      for (int c = 0; c <= wbl; c++) begin
        if (abort && c == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
        pmem_resp = (c == wbl);
        cyc("writeback", ov(1'b0, 1'b0, 1'b1, vh, 2'b00, 2'b00, 1'b0));
      end
    end
    for (int c = 0; c <= fl; c++) begin
      if (abort && c == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
      pmem_resp = (c == fl);
      cyc("fill", ov(1'b0, 1'b1, 1'b0, 2'b00, (c == fl) ? vh : 2'b00, 2'b00, 1'b0));
    end
    pmem_resp = 1'b0;
    if (abort) begin
      pmem_resp = 1'b1;
      cyc("abort_idle", 10'd0);
      pmem_resp = 1'b0;
      cyc("abort_idle2", 10'd0);
    end else begin
      hit_one = !v; hit_two = v;
      ww = wr ? vh : 2'b00;
      cyc("retry_hit", ov(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, ww, !wr && v));
      lru_m[idx] = !v;
    end
    clear_in();
  endtask

  task automatic reset_mid_fill(input logic [2:0] idx);
    clear_in();
    mem_read = 1'b1; mem_address = addr(idx);
    dirty_one = 1'b0; dirty_two = 1'b0;
    if (lru_m[idx]) begin dirty_two = 1'b0; end else begin dirty_one = 1'b0; end
    cyc("rst_miss", 10'd0);
    cyc("rst_fill0", ov(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    cyc("rst_fill1", ov(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    rst_n = 1'b0;
    hit_one = 1'b1;
    #1;
    check_eq("rst_async", obs, 10'd0);
    @(negedge clk);
    check_eq("rst_hold", obs, 10'd0);
    for (int i = 0; i < 8; i++) lru_m[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    mem_address = 16'h0000;
    for (int i = 0; i < 8; i++) lru_m[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_read = 1'b1; hit_one = 1'b1; pmem_resp = 1'b1;
    @(negedge clk);
    check_eq("reset_outputs", obs, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_in();

    // Read hits at index 3, then a dirty miss reveals LRU[3]=1.
    hit_req(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    hit_req(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    miss_req(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1, 1, 1'b0);
    // Clean miss at index 5 with slow memory.
    miss_req(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 0, 4, 1'b0);
    // Dirty miss at index 2 with way two as victim.
    hit_req(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    miss_req(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 3, 2, 1'b0);
    // Write hits: write alone, both strobes, and both hit lines (way one wins).
    hit_req(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    hit_req(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    hit_req(1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
    hit_req(1'b0, 1'b1, 3'd6, 1'b1, 1'b1);
    // Abort during writeback, then during a clean fill.
    miss_req(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 2, 2, 1'b1);
    miss_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0, 3, 1'b1);
    // Reset during a fill, then prove every LRU entry cleared.
    reset_mid_fill(3'd6);
    hit_req(1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) miss_req(1'b0, 1'b1, 3'(i), 1'b1, 1'b1, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] idx;
      bit wr, rd, h1, h2;
      idx = 3'($urandom);
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      if ($urandom_range(0, 3) == 0) idle_cyc();
      if ($urandom_range(0, 1) == 0) begin
        h1 = 1'($urandom);
        h2 = h1 ? 1'($urandom) : 1'b1;
        hit_req(wr, rd, idx, h1, h2);
      end else begin
        miss_req(wr, rd, idx, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 7) == 0);
      end
    end
    idle_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; the ports are clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mem_read / mem_write  in  1 each  CPU request strobes, held high until mem_resp.
REQ-005 mem_address  in  16  CPU word address: tag [15:6], index [5:3], word offset [2:0].
REQ-006 mem_resp  out  1  one-cycle CPU completion pulse.
REQ-007 hit_one / hit_two  in  1 each  datapath tag match AND valid for way one / way two at mem_address index.
REQ-008 dirty_one / dirty_two  in  1 each  dirty bit of way one / way two at the current index.
REQ-009 pmem_read / pmem_write  out  1 each  physical-memory line request strobes.
REQ-010 pmem_resp  in  1  physical-memory completion pulse.
REQ-011 pmem_addr_sel  out  2  address mux: 0 = {mem_address[15:3],3'b0}, 1 = way-one tag writeback line, 2 = way-two tag writeback line; 3 is unused.
REQ-012 load_way  out  2  one-hot fill enable: write line, tag and valid=1, and clear dirty in the selected way.
REQ-013 write_way  out  2  one-hot CPU write-hit enable: merge word and set dirty in the selected way.
REQ-014 out_way  out  1  read-data way select: 0 = way one, 1 = way two.

Function
REQ-015 States SHALL be IDLE, WRITEBACK and FILL only.
REQ-016 The block SHALL hold an internal 8-entry x 1-bit LRU array indexed by mem_address[5:3], where 0 marks way one as LRU and 1 marks way two as LRU.
REQ-017 A request SHALL be mem_read|mem_write; when both strobes are high, the request SHALL be treated as a write.
REQ-018 In IDLE, a request with a hit SHALL assert mem_resp combinationally in the same cycle (zero-wait hit).
REQ-019 If hit_one and hit_two are both high, way one SHALL win.
REQ-020 On a read hit, out_way SHALL equal the hit way.
REQ-021 On a write hit, write_way SHALL be one-hot for the hit way, for that cycle only.
REQ-022 On any hit, the LRU entry for the index SHALL be set at the clock edge to the non-hit way.
REQ-023 In IDLE, a request with a miss SHALL register victim = LRU[index] at the clock edge.
REQ-024 On a miss, if the victim's dirty bit is set, the next state SHALL be WRITEBACK; otherwise it SHALL be FILL.
REQ-025 On a miss, mem_resp SHALL stay 0.
REQ-026 In WRITEBACK, pmem_write SHALL be 1 and pmem_addr_sel SHALL be 1+victim.
REQ-027 In WRITEBACK, on pmem_resp the next state SHALL be FILL.
REQ-028 In FILL, pmem_read SHALL be 1 and pmem_addr_sel SHALL be 0.
REQ-029 In FILL, on pmem_resp, load_way[victim] SHALL be 1 for that cycle and the next state SHALL be IDLE.
REQ-030 After a fill, the retried request SHALL hit on the next IDLE cycle, giving a miss latency of (writeback cycles)+(fill cycles)+1.
REQ-031 The pmem strobes SHALL stay high until pmem_resp and SHALL never both be 1 in the same cycle.
REQ-032 A pmem_resp that arrives while in IDLE SHALL be ignored.
REQ-033 If the CPU drops its request mid-miss, the current pmem transaction (and any FILL) SHALL complete, and the block SHALL then return to IDLE without asserting mem_resp.
REQ-034 The victim register SHALL NOT change outside the IDLE miss edge.
REQ-035 All outputs SHALL be 0 in any state and cycle not stated above.

Reset
REQ-036 While rst_n=0, the state SHALL be IDLE, all LRU entries and the victim register SHALL be 0, and every output SHALL be 0 asynchronously.
REQ-037 Reset asserted mid-WRITEBACK or mid-FILL SHALL drop pmem_read/pmem_write immediately and abandon the transaction.
REQ-038 After rst_n rises, the first request SHALL be evaluated in IDLE on the next rising edge.

Verification
REQ-039 Read hit: hit_two=1, mem_read=1, index 3 -> same-cycle mem_resp=1 and out_way=1, then LRU[3]=0; second read with hit_one -> LRU[3]=1.
REQ-040 Clean miss: index 5, LRU[5]=0, dirty_one=0, pmem_resp delayed 4 cycles -> FILL with pmem_read=1 and pmem_addr_sel=0, load_way=2'b01 on the resp cycle, mem_resp one cycle after the fill once hit_one=1.
REQ-041 Dirty miss: LRU[2]=1, dirty_two=1 -> WRITEBACK with pmem_write=1 and pmem_addr_sel=2 until resp, then FILL, then load_way=2'b10; pmem_read and pmem_write never overlap.
REQ-042 Write hit: mem_write=1, hit_one=1 -> write_way=2'b01 and mem_resp=1 in the same single cycle; both strobes high behaves identically.
REQ-043 Reset mid-FILL: rst_n=0 two cycles into FILL -> pmem_read=0 immediately, all LRU entries read 0; after release, a hit request responds normally.
REQ-044 Abort: mem_read dropped during WRITEBACK -> WRITEBACK and FILL complete, no mem_resp, return to IDLE; a spurious pmem_resp in IDLE has no effect.
